// File: rtl/vga_dac_pkg.sv
// Shared VGA types and default 640x480@60 timing for the pattern DAC driver.
package vga_dac_pkg;
  typedef enum logic [1:0] {
    MODE_BARS   = 2'd0,
    MODE_GRAD   = 2'd1,
    MODE_CHECK  = 2'd2,
    MODE_SCROLL = 2'd3
  } mode_e;

  localparam int CNT_W = 10;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  function automatic logic in_range(input logic [CNT_W-1:0] x, input int lo, input int hi);
    return (int'(x) >= lo) && (int'(x) < hi);
  endfunction
endpackage

// File: rtl/vga_dac_timing.sv
// Raster counters plus combinational sync/blank decode of the current (h,v) state.
module vga_timing
  import vga_dac_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v,
  output logic             line_end,
  output logic             wrap,
  output logic             hsync_act,
  output logic             vsync_act,
  output logic             hblank,
  output logic             vblank
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  assign line_end = (h == CNT_W'(H_TOTAL - 1));
  assign wrap     = line_end && (v == CNT_W'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (ena) begin
      if (line_end) begin
        h <= '0;
        v <= wrap ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  assign hsync_act = in_range(h, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC);
  assign vsync_act = in_range(v, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC);
  assign hblank    = int'(h) >= H_ACTIVE;
  assign vblank    = int'(v) >= V_ACTIVE;
endmodule

// File: rtl/vga_dac_driver.sv
// Test-pattern generator for R2R DACs; all outputs registered one cycle after the counters.
// Optional scrolling gradient (mode 3 + frame counter) enabled by defining VGA_SCROLL_EN.
module vga_dac_driver
  import vga_dac_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int DAC_BITS = 8,
  parameter int SYNC_NEG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [1:0]          mode,
  output logic [DAC_BITS-1:0] dr,
  output logic [DAC_BITS-1:0] dg,
  output logic [DAC_BITS-1:0] db,
  output logic                hsync,
  output logic                vsync,
  output logic                hblank,
  output logic                vblank,
  output logic                frame_tick,
  output logic [CNT_W-1:0]    hpos,
  output logic [CNT_W-1:0]    vpos
);
  localparam int BAR_W = H_ACTIVE / 8;

  logic [CNT_W-1:0] h, v;
  logic line_end, wrap, hs_act, vs_act, hb, vb;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk), .rst_n(rst_n), .ena(ena), .h(h), .v(v),
    .line_end(line_end), .wrap(wrap), .hsync_act(hs_act), .vsync_act(vs_act),
    .hblank(hb), .vblank(vb)
  );

  mode_e            mode_q;
  logic [CNT_W-1:0] bar_px;
  logic [2:0]       bar_idx;

  // Bar index tracks h incrementally so no divide by H_ACTIVE/8 is needed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bar_px  <= '0;
      bar_idx <= '0;
      mode_q  <= MODE_BARS;
    end else if (ena) begin
      if (line_end) begin
        bar_px  <= '0;
        bar_idx <= '0;
      end else if (bar_px == CNT_W'(BAR_W - 1)) begin
        bar_px  <= '0;
        bar_idx <= bar_idx + 1'b1;
      end else begin
        bar_px <= bar_px + 1'b1;
      end
      if (wrap) mode_q <= mode_e'(mode);
    end
  end

`ifdef VGA_SCROLL_EN
  logic [7:0]          fcnt;
  logic [DAC_BITS-1:0] sh;

  always_ff @(posedge clk) begin
    if (!rst_n)           fcnt <= '0;
    else if (ena && wrap) fcnt <= fcnt + 1'b1;
  end

  assign sh = h[DAC_BITS-1:0] + fcnt[DAC_BITS-1:0];
`endif

  logic [DAC_BITS-1:0] pr, pg, pb;

  always_comb begin
    pr = '0;
    pg = '0;
    pb = '0;
    case (mode_q)
      MODE_GRAD: begin
        pr = h[DAC_BITS-1:0];
        pg = v[DAC_BITS-1:0];
        pb = h[DAC_BITS-1:0] ^ v[DAC_BITS-1:0];
      end
      MODE_CHECK: begin
        pr = {DAC_BITS{h[4] ^ v[4]}};
        pg = pr;
        pb = pr;
      end
`ifdef VGA_SCROLL_EN
      MODE_SCROLL: begin
        pr = sh;
        pg = v[DAC_BITS-1:0];
        pb = sh ^ v[DAC_BITS-1:0];
      end
`endif
      default: begin
        pr = {DAC_BITS{bar_idx[2]}};
        pg = {DAC_BITS{bar_idx[1]}};
        pb = {DAC_BITS{bar_idx[0]}};
      end
    endcase
    if (hb || vb) begin
      pr = '0;
      pg = '0;
      pb = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dr         <= '0;
      dg         <= '0;
      db         <= '0;
      hsync      <= (SYNC_NEG != 0);
      vsync      <= (SYNC_NEG != 0);
      hblank     <= 1'b0;
      vblank     <= 1'b0;
      frame_tick <= 1'b0;
      hpos       <= '0;
      vpos       <= '0;
    end else if (ena) begin
      dr         <= pr;
      dg         <= pg;
      db         <= pb;
      hsync      <= hs_act ^ (SYNC_NEG != 0);
      vsync      <= vs_act ^ (SYNC_NEG != 0);
      hblank     <= hb;
      vblank     <= vb;
      frame_tick <= (h == '0) && (v == '0);
      hpos       <= h;
      vpos       <= v;
    end else begin
      // Frozen: everything holds except the tick, which must not stretch.
      frame_tick <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vga_dac_driver.sv
// Self-checking bench for vga_dac_driver on a reduced raster, against a position-arithmetic model.
module tb_vga_dac_driver;
  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 32, VF = 2, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic [7:0] r, g, b;
    logic       hs, vs, hb, vb, ft;
    logic [9:0] hp, vp;
  } out_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] dr, dg, db;
  logic       hsync, vsync, hblank, vblank, frame_tick;
  logic [9:0] hpos, vpos;

  int errs = 0, checks = 0;
  int n = 0, mlat = 0;
  out_t expv, obs, snap;
  int cyc = 0, last_tick = -1, period = 0;
  int hs_acc = 0, vs_acc = 0, hs_frame = 0, vs_frame = 0;

  vga_dac_driver #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .DAC_BITS(8), .SYNC_NEG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode),
    .dr(dr), .dg(dg), .db(db), .hsync(hsync), .vsync(vsync),
    .hblank(hblank), .vblank(vblank), .frame_tick(frame_tick),
    .hpos(hpos), .vpos(vpos)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ones(input bit b);
    return b ? 8'hFF : 8'h00;
  endfunction

  // Expected registered outputs for the k-th raster position after reset.
  function automatic out_t model(input int k, input int m);
    out_t o;
    int h, v, fr, i;
    h  = k % HT;
    v  = (k / HT) % VT;
    fr = k / FRAME;
    o    = '0;
    o.hs = !(h >= HA + HF && h < HA + HF + HS);
    o.vs = !(v >= VA + VF && v < VA + VF + VS);
    o.hb = (h >= HA);
    o.vb = (v >= VA);
    o.ft = (h == 0 && v == 0);
    o.hp = 10'(h);
    o.vp = 10'(v);
`ifndef VGA_SCROLL_EN
    if (m == 3) m = 0;
`endif
    if (!o.hb && !o.vb) begin
      case (m)
        1: begin o.r = 8'(h); o.g = 8'(v); o.b = 8'(h ^ v); end
        2: begin
          o.r = ones((((h >> 4) ^ (v >> 4)) % 2) == 1);
          o.g = o.r;
          o.b = o.r;
        end
        3: begin i = h + fr % 256; o.r = 8'(i); o.g = 8'(v); o.b = 8'(i ^ v); end
        default: begin
          i = h / (HA / 8);
          o.r = ones(i[2]); o.g = ones(i[1]); o.b = ones(i[0]);
        end
      endcase
    end
    return o;
  endfunction

  task automatic chk(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task cycle(input bit r, input bit e, input logic [1:0] md);
    rst_n = r;
    ena   = e;
    mode  = md;
    if (!r) begin
      expv = '0; expv.hs = 1'b1; expv.vs = 1'b1;
      n = 0; mlat = 0;
    end else if (e) begin
      expv = model(n, mlat);
      if ((n + 1) % FRAME == 0) mlat = int'(md);
      n++;
    end else begin
      expv.ft = 1'b0;
    end
    @(posedge clk);
    #1;
    obs = {dr, dg, db, hsync, vsync, hblank, vblank, frame_tick, hpos, vpos};
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL outputs n=%0d observed=%h expected=%h", n, obs, expv);
    end
    if (!rst_n) begin
      cyc = 0; last_tick = -1; hs_acc = 0; vs_acc = 0;
    end else if (ena) begin
      cyc++;
      if (frame_tick) begin
        if (last_tick >= 0) begin
          period = cyc - last_tick; hs_frame = hs_acc; vs_frame = vs_acc;
        end
        last_tick = cyc; hs_acc = 0; vs_acc = 0;
      end
      hs_acc += hsync ? 0 : 1;
      vs_acc += vsync ? 0 : 1;
    end
  endtask

  // Run with ena high until a tick or a given position; bounded at two frames.
  task automatic seek(input logic [1:0] md, input int hp, input int vp, input bit tick);
    bit found = 1'b0;
    for (int k = 0; k < 2 * FRAME && !found; k++) begin
      cycle(1'b1, 1'b1, md);
      found = tick ? frame_tick : (hpos == 10'(hp) && (vp < 0 || vpos == 10'(vp)));
    end
    chk("seek", int'(found), 1);
  endtask

  initial begin
    logic [1:0] md;
    repeat (2) cycle(1'b0, 1'b1, 2'd0);
    chk("reset_hsync", int'(hsync), 1);
    chk("reset_dr", int'(dr), 0);
    cycle(1'b1, 1'b1, 2'd0);
    chk("first_tick", int'(frame_tick), 1);
    repeat (2 * FRAME + 4) cycle(1'b1, 1'b1, 2'd0);
    chk("frame_period", period, FRAME);
    chk("hsync_low", hs_frame, HS * VT);
    chk("vsync_low", vs_frame, VS * HT);

    // Mid-frame mode change must wait for the next frame.
    seek(2'd0, 0, 10, 1'b0);
    seek(2'd2, 8, -1, 1'b0);
    chk("bars_db", int'(db), 255);
    chk("bars_dr", int'(dr), 0);
    seek(2'd2, 56, -1, 1'b0);
    chk("bars_white", int'(dg), 255);
    seek(2'd2, 64, -1, 1'b0);
    chk("blank_h", int'(hblank), 1);
    chk("blank_dr", int'(dr), 0);
    seek(2'd2, 0, 0, 1'b1);
    seek(2'd2, 16, 0, 1'b0);
    chk("checker_16_0", int'(dr), 255);

    md = 2'd1;
    for (int k = 0; k < 15000; k++) begin
      if ($urandom_range(0, 299) == 0) md = 2'($urandom_range(0, 3));
      cycle($urandom_range(0, 4999) != 0, $urandom_range(0, 15) != 0, md);
    end

    seek(2'd1, 20, 5, 1'b0);
    snap = obs;
    repeat (50) cycle(1'b1, 1'b0, 2'd1);
    chk("freeze_dr", int'(dr), int'(snap.r));
    chk("freeze_hpos", int'(hpos), int'(snap.hp));
    cycle(1'b0, 1'b0, 2'd1);
    chk("rst_hpos", int'(hpos), 0);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_hblank", int'(hblank), 0);

    cycle(1'b1, 1'b1, 2'd3);
    for (int f = 1; f <= 5; f++) seek(2'd3, 0, 0, 1'b1);
`ifdef VGA_SCROLL_EN
    chk("scroll_f5_dr", int'(dr), 5);
    seek(2'd3, 8, 0, 1'b0);
    chk("scroll_f5_db", int'(db), 13);
`else
    chk("mode3_f5_dr", int'(dr), 0);
    seek(2'd3, 8, 0, 1'b0);
    chk("mode3_bars_db", int'(db), 255);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/vga_dac_driver.md
VGA_DAC_DRIVER -- requirements
Module: vga_dac_driver

Interface
REQ-001 SHALL have parameters H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48: horizontal timing in pixel clocks.
REQ-002 SHALL have parameters V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33: vertical timing in lines.
REQ-003 SHALL have parameter DAC_BITS=8: width of each colour channel driven to the R2R DACs; legal range 1..8.
REQ-004 SHALL have parameter SYNC_NEG=1: 1 means sync pulses are active-low, 0 means active-high.
REQ-005 SHALL have port clk, input, 1 bit: pixel clock, the only clock.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port ena, input, 1 bit: 0 freezes all state.
REQ-008 SHALL have port mode, input, 2 bits: pattern select (0 bars, 1 gradient, 2 checker, 3 scroll).
REQ-009 SHALL have ports dr, dg, db, output, DAC_BITS each: colour codes to the DACs.
REQ-010 SHALL have ports hsync, vsync, output, 1 bit each: sync at the polarity set by SYNC_NEG.
REQ-011 SHALL have ports hblank, vblank, output, 1 bit each: high outside the active region.
REQ-012 SHALL have port frame_tick, output, 1 bit: one-cycle pulse at frame start.
REQ-013 SHALL have ports hpos and vpos, output, 10 bits each: pixel position aligned with the colour outputs.

Function
REQ-014 SHALL count h from 0 to H_TOTAL-1 (H_TOTAL = sum of the H parameters), then wrap to 0 and increment v; v wraps at V_TOTAL-1.
REQ-015 SHALL register every output from the counter state, giving exactly 1-cycle latency with all outputs mutually aligned.
REQ-016 SHALL assert hsync while H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync is asserted on the same rule using the V parameters.
REQ-017 SHALL assert hblank while h >= H_ACTIVE and vblank while v >= V_ACTIVE.
REQ-018 SHALL force dr, dg and db to 0 whenever hblank or vblank is asserted.
REQ-019 SHALL pulse frame_tick for the single output cycle that corresponds to counter state (0,0).
REQ-020 SHALL sample mode only on the cycle the counters wrap to (0,0); mid-frame changes to mode take effect at the next frame.
REQ-021 Mode 0 SHALL draw 8 bars of width H_ACTIVE/8 using a bar counter (no divider); with bar index i, each of dr/dg/db is all-ones when i[2]/i[1]/i[0] is 1, else 0.
REQ-022 Mode 1 SHALL output dr = h[DAC_BITS-1:0], dg = v[DAC_BITS-1:0], db = (h^v)[DAC_BITS-1:0].
REQ-023 Mode 2 SHALL drive all channels all-ones when h[4]^v[4] is 1, else 0 (a 16x16 checker).
REQ-024 Mode 3 SHALL behave as mode 1 with h replaced by h+fcnt, where fcnt is an 8-bit frame counter that increments on each frame_tick and wraps at 255.
REQ-025 SHALL, while ena is 0, hold all counters, the latched mode and all outputs; frame_tick SHALL NOT re-pulse while frozen.
REQ-026 SHALL truncate all pattern arithmetic to DAC_BITS without saturation.

Reset
REQ-027 SHALL, on rst_n low at a clk edge, set h=0, v=0, fcnt=0 and the latched mode to 0, regardless of ena.
REQ-028 SHALL reset outputs to: dr/dg/db 0, hpos/vpos 0, hblank/vblank 0, frame_tick 0, hsync/vsync at their inactive level.
REQ-029 SHALL produce frame_tick one cycle after the first rst_n-high edge; reset asserted mid-frame restarts timing from (0,0).

Configuration
REQ-030 SHALL implement mode 3 and fcnt only when macro VGA_SCROLL_EN is defined.
REQ-031 SHALL, without VGA_SCROLL_EN, omit fcnt and treat mode 3 as mode 0.

Structure
REQ-032 SHALL import from package vga_dac_pkg: the mode enum, the default 640x480 timing constants and the counter width (10).
REQ-033 SHALL place the counters, sync and blank generation in sub-module vga_timing; vga_dac_driver instantiates it and adds the pattern logic and output registers.

Verification
REQ-034 Reset, then run one full frame with default parameters -> frame_tick period 420000 cycles; hsync low for 96 cycles per line; vsync low for 2 lines.
REQ-035 mode=0 -> at hpos=80 the outputs are dr=0, dg=0, db=255; at hpos=560 they are 255/255/255; at hpos=640 all channels are 0 with hblank=1.
REQ-036 mode=1, DAC_BITS=4 -> at (hpos=19, vpos=7) the outputs are dr=3, dg=7, db=4.
REQ-037 Change mode from 0 to 2 at vpos=100 -> bars continue until the next frame_tick, then the checker appears with (16,0) giving 255.
REQ-038 VGA_SCROLL_EN defined, mode=3 -> on frame 5, (hpos=0, vpos=0) gives dr=5; without the macro, mode=3 matches mode 0 exactly.
REQ-039 Hold ena=0 for 50 cycles mid-line, then assert rst_n low for 1 cycle -> outputs frozen during the hold, then all reset values per REQ-028.
